// File: rtl/mem_arb_pkg.sv
// Shared encodings for the core/DMA memory arbiter: read-owner tags,
// arbitration states and the default starvation threshold.
package mem_arb_pkg;

  localparam int STARVE_MAX_DEF = 8;
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_FORCE  = 1'b1
  } arb_state_e;

  function automatic logic is_read(input logic [3:0] we);
    return (we == 4'h0);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive denied DMA cycles; hit flags the edge on
// which the count would reach the threshold, and the count restarts there.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    hit   = inc && (cnt_q == (MAX_CNT - CNT_W'(1)));
    cnt_d = cnt_q;
    if (clr || hit) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single synchronous-read memory port: the core
// has priority, and a starved DMA stream earns one forced grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic [3:0]        core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_stall,
  output logic [31:0]       core_rdata,
  output logic              core_rvalid,
  input  logic              dma_valid,
  input  logic [3:0]        dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_ready,
  output logic [31:0]       dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output arb_state_e        dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  // Handshakes: the core holds core_req/we/addr/wdata stable while
  // core_stall=1; a DMA beat transfers on a cycle with dma_valid && dma_ready
  // and is held stable while dma_valid && !dma_ready.

  arb_state_e       state_q;
  arb_state_e       state_d;
  owner_e           owner_q;
  owner_e           owner_d;
  logic             core_gnt;
  logic             dma_gnt;
  logic             starve_inc;
  logic             starve_clr;
  logic             starve_hit;
  logic [CNT_W-1:0] starve_cnt;

  // Grants are forced off while reset is held so the port stays quiet.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (rst_n) begin
      if (state_q == S_FORCE) begin
        if (dma_valid) begin
          dma_gnt = 1'b1;
        end else if (core_req) begin
          core_gnt = 1'b1;
        end
      end else begin
        if (core_req) begin
          core_gnt = 1'b1;
        end else if (dma_valid) begin
          dma_gnt = 1'b1;
        end
      end
    end
  end

  assign core_stall = core_req & ~core_gnt;
  assign dma_ready  = dma_gnt;

  always_comb begin
    mem_en    = core_gnt | dma_gnt;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign starve_inc = (state_q == S_NORMAL) & dma_valid & ~dma_gnt;
  assign starve_clr = (state_q != S_NORMAL) | ~dma_valid | dma_gnt;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .cnt   (starve_cnt),
    .hit   (starve_hit)
  );

  // S_FORCE lasts exactly one cycle: either the DMA beat is taken or the
  // stream went idle, and both cases return to core priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NORMAL: if (starve_hit) state_d = S_FORCE;
      S_FORCE:  state_d = S_NORMAL;
      default:  state_d = S_NORMAL;
    endcase
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (core_gnt && is_read(core_we)) begin
      owner_d = OWN_CORE;
    end else if (dma_gnt && is_read(dma_we)) begin
      owner_d = OWN_DMA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NORMAL;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign core_rvalid    = (owner_q == OWN_CORE);
  assign dma_rvalid     = (owner_q == OWN_DMA);
  assign core_rdata     = mem_rdata;
  assign dma_rdata      = mem_rdata;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt;

  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
    !(core_gnt && dma_gnt));

  a_force_short: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_FORCE) |=> (state_q == S_NORMAL));

endmodule
